// File: rtl/soc_perip_pkg.sv
// Shared SoC peripheral definitions: UART register map, CTRL/STAT
// bit positions and the TX feeder FSM state type.
package soc_perip_pkg;

  localparam logic [31:0] UART_MASK = 32'h0000_000f;

  localparam logic [31:0] RXDT = 32'h0;
  localparam logic [31:0] TXDT = 32'h4;
  localparam logic [31:0] CTRL = 32'h8;
  localparam logic [31:0] STAT = 32'hc;

  localparam int CTRL_RX_EN   = 0;
  localparam int CTRL_TX_EN   = 1;
  localparam int STAT_TX_BUSY = 1;

  localparam logic [31:0] CTRL_EN_ALL =
    (32'd1 << CTRL_RX_EN) | (32'd1 << CTRL_TX_EN);

  typedef enum logic [1:0] {
    ST_CFG,
    ST_POLL,
    ST_WRITE,
    ST_GAP
  } feeder_state_e;

  function automatic logic [31:0] reg_addr(
    input logic [31:0] base,
    input logic [31:0] off
  );
    return (base & ~UART_MASK) | (off & UART_MASK);
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Feeder bundle: producer valid/ready byte stream plus the UART
// register port. master = feeder side, slave = producer/UART side.
interface uart_tx_feeder_if #(
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          flush;
  logic [AW:0]   level;
  logic          busy;
  logic          bus_we;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;

  modport master (
    input  in_valid, in_data, flush, bus_rdata,
    output in_ready, level, busy,
    output bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output in_valid, in_data, flush, bus_rdata,
    input  in_ready, level, busy,
    input  bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with AW+1 bit pointers; push/pop/flush,
// full/empty/level. Ports: clk, rst (async low), push/pop/flush, data.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // no bypass: a full FIFO refuses even when popping
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// UART TX feeder: queues producer bytes and, as bus master, enables
// the UART once, polls STAT and writes TXDT. Ports: clk, rst, bus.
module uart_tx_feeder
  import soc_perip_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter logic [31:0] UART_BASE = 32'hffff0020,
  parameter int          GAP       = 2
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_feeder_if.master bus
);

  feeder_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    head;
  logic          full, empty, pop;
  logic          we;
  logic [31:0]   addr, wdata;
  logic          unused_rdata;

  assign unused_rdata = ^{bus.bus_rdata[31:2], bus.bus_rdata[0]};

  sync_fifo #(.W(8), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .wdata_i (bus.in_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (bus.level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    addr    = reg_addr(UART_BASE, STAT);
    wdata   = '0;
    pop     = 1'b0;
    unique case (state_q)
      ST_CFG: begin
        we      = 1'b1;
        addr    = reg_addr(UART_BASE, CTRL);
        wdata   = CTRL_EN_ALL;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        // a flushing FIFO must not launch a write of a dropped byte
        if (!empty && !bus.flush &&
            !bus.bus_rdata[STAT_TX_BUSY])
          state_d = ST_WRITE;
      end
      ST_WRITE: begin
        we      = 1'b1;
        addr    = reg_addr(UART_BASE, TXDT);
        wdata   = {24'b0, head};
        pop     = 1'b1;
        cnt_d   = 4'(GAP);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // hides the UART's one-cycle STAT busy set latency
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) state_d = ST_POLL;
      end
      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CFG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.busy      = ~empty | (state_q != ST_POLL);
  assign bus.bus_we    = we;
  assign bus.bus_addr  = addr;
  assign bus.bus_wdata = wdata;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small UART STAT model.
// Each scenario task drives stimulus and checks results inline.
module tb_uart_tx_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.AW(4)) ifc ();

  uart_tx_feeder #(
    .DEPTH(16), .AW(4),
    .UART_BASE(32'hffff0020), .GAP(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int compared = 0;
  int mismatched = 0;

  logic force_busy = 1'b0;
  int   tx_len = 0;
  int   tx_cnt = 0;
  logic stat_busy;

  assign stat_busy = force_busy | (tx_cnt != 0);
  assign ifc.bus_rdata = {30'b0, stat_busy, 1'b0};

  always @(posedge clk) begin
    if (ifc.bus_we && ifc.bus_addr == 32'hffff0024)
      tx_cnt <= tx_len;
    else if (tx_cnt != 0)
      tx_cnt <= tx_cnt - 1;
  end

  logic [7:0] obs[$];
  int   cfg_cnt = 0;
  int   viol = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst && ifc.bus_we && ifc.bus_addr == 32'hffff0024) begin
      obs.push_back(ifc.bus_wdata[7:0]);
      if (prev_busy) viol++;
    end
    if (rst && ifc.bus_we && ifc.bus_addr == 32'hffff0028)
      cfg_cnt++;
    prev_busy = stat_busy;
  end

  task automatic test_reset();
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'h00;
    ifc.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (ifc.level !== 5'd0) begin mismatched++;
      $display("FAIL rst_level: got %0d want 0", ifc.level); end
    compared++; if (ifc.in_ready !== 1'b1) begin mismatched++;
      $display("FAIL rst_ready: got %b want 1", ifc.in_ready); end
    compared++; if (ifc.busy !== 1'b1) begin mismatched++;
      $display("FAIL rst_busy: got %b want 1", ifc.busy); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    compared++; if (ifc.bus_we !== 1'b1) begin mismatched++;
      $display("FAIL cfg_we: got %b want 1", ifc.bus_we); end
    compared++; if (ifc.bus_addr !== 32'hffff0028) begin mismatched++;
      $display("FAIL cfg_addr: got %h want ffff0028", ifc.bus_addr); end
    compared++; if (ifc.bus_wdata !== 32'h3) begin mismatched++;
      $display("FAIL cfg_wdata: got %h want 3", ifc.bus_wdata); end
    @(negedge clk);
    compared++; if (ifc.bus_we !== 1'b0) begin mismatched++;
      $display("FAIL poll_we: got %b want 0", ifc.bus_we); end
    compared++; if (ifc.bus_addr !== 32'hffff002c) begin mismatched++;
      $display("FAIL poll_addr: got %h want ffff002c", ifc.bus_addr); end
    compared++; if (ifc.busy !== 1'b0) begin mismatched++;
      $display("FAIL poll_busy: got %b want 0", ifc.busy); end
    repeat (3) @(negedge clk);
    compared++; if (cfg_cnt !== 1) begin mismatched++;
      $display("FAIL cfg_once: got %0d want 1", cfg_cnt); end
  endtask

  task automatic test_single();
    obs.delete();
    force_busy = 1'b0;
    tx_len = 0;
    @(posedge clk); #1;
    ifc.in_valid = 1'b1;
    ifc.in_data = 8'h41;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    compared++; if (ifc.level !== 5'd1) begin mismatched++;
      $display("FAIL single_lvl1: got %0d want 1", ifc.level); end
    compared++; if (ifc.bus_we !== 1'b0) begin mismatched++;
      $display("FAIL single_early: got %b want 0", ifc.bus_we); end
    @(negedge clk);
    compared++; if (ifc.bus_we !== 1'b1) begin mismatched++;
      $display("FAIL single_we: got %b want 1", ifc.bus_we); end
    compared++; if (ifc.bus_addr !== 32'hffff0024) begin mismatched++;
      $display("FAIL single_addr: got %h want ffff0024", ifc.bus_addr); end
    compared++; if (ifc.bus_wdata !== 32'h41) begin mismatched++;
      $display("FAIL single_wdata: got %h want 41", ifc.bus_wdata); end
    @(negedge clk);
    compared++; if (ifc.level !== 5'd0) begin mismatched++;
      $display("FAIL single_lvl0: got %0d want 0", ifc.level); end
    compared++; if (ifc.bus_we !== 1'b0) begin mismatched++;
      $display("FAIL single_gap_we: got %b want 0", ifc.bus_we); end
    repeat (4) @(negedge clk);
    compared++; if (obs.size() !== 1) begin mismatched++;
      $display("FAIL single_count: got %0d want 1", obs.size()); end
    compared++; if (ifc.busy !== 1'b0) begin mismatched++;
      $display("FAIL single_idle: got %b want 0", ifc.busy); end
  endtask

  task automatic test_fill();
    int c;
    obs.delete();
    force_busy = 1'b1;
    tx_len = 3;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data = 8'(8'h10 + i);
      @(posedge clk); #1;
    end
    ifc.in_data = 8'hee;
    @(negedge clk);
    compared++; if (ifc.level !== 5'd16) begin mismatched++;
      $display("FAIL fill_level: got %0d want 16", ifc.level); end
    compared++; if (ifc.in_ready !== 1'b0) begin mismatched++;
      $display("FAIL fill_ready: got %b want 0", ifc.in_ready); end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    compared++; if (ifc.level !== 5'd16) begin mismatched++;
      $display("FAIL fill_17th: got %0d want 16", ifc.level); end
    compared++; if (obs.size() !== 0) begin mismatched++;
      $display("FAIL fill_nowr: got %0d want 0", obs.size()); end
    @(posedge clk); #1;
    force_busy = 1'b0;
    c = 0;
    while (ifc.level != 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    compared++; if (ifc.level !== 5'd0) begin mismatched++;
      $display("FAIL fill_drain: got %0d want 0", ifc.level); end
    compared++; if (obs.size() !== 16) begin mismatched++;
      $display("FAIL fill_count: got %0d want 16", obs.size()); end
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (obs[i] !== 8'(8'h10 + i)) begin mismatched++;
        $display("FAIL fill_order[%0d]: got %h want %h",
                 i, obs[i], 8'(8'h10 + i)); end
    end
    compared++; if (viol !== 0) begin mismatched++;
      $display("FAIL fill_stat: got %0d want 0", viol); end
  endtask

  task automatic test_wrap();
    int nxt;
    int w;
    int c;
    obs.delete();
    force_busy = 1'b1;
    tx_len = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    force_busy = 1'b0;
    nxt = 5;
    for (int k = 0; k < 35; k++) begin
      w = 0;
      @(negedge clk);
      while (!(ifc.bus_we && ifc.bus_addr == 32'hffff0024) && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) begin
        compared++; mismatched++;
        $display("FAIL wrap_timeout: got no write want write");
        break;
      end
      ifc.in_valid = 1'b1;
      ifc.in_data = 8'(8'h80 + nxt);
      nxt++;
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
      @(negedge clk);
      compared++; if (ifc.level !== 5'd5) begin mismatched++;
        $display("FAIL wrap_level: got %0d want 5", ifc.level); end
    end
    c = 0;
    while (ifc.level != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    compared++; if (obs.size() !== 40) begin mismatched++;
      $display("FAIL wrap_count: got %0d want 40", obs.size()); end
    for (int i = 0; i < 40; i++) begin
      compared++;
      if (obs[i] !== 8'(8'h80 + i)) begin mismatched++;
        $display("FAIL wrap_order[%0d]: got %h want %h",
                 i, obs[i], 8'(8'h80 + i)); end
    end
  endtask

  task automatic test_flush();
    int w;
    obs.delete();
    force_busy = 1'b1;
    tx_len = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data = 8'(8'ha0 + i);
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    force_busy = 1'b0;
    w = 0;
    @(negedge clk);
    while (!(ifc.bus_we && ifc.bus_addr == 32'hffff0024) && w < 20) begin
      @(negedge clk);
      w++;
    end
    compared++; if (ifc.level !== 5'd6) begin mismatched++;
      $display("FAIL flush_pre: got %0d want 6", ifc.level); end
    ifc.flush = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data = 8'hee;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    compared++; if (ifc.level !== 5'd0) begin mismatched++;
      $display("FAIL flush_level: got %0d want 0", ifc.level); end
    compared++; if (ifc.bus_we !== 1'b0) begin mismatched++;
      $display("FAIL flush_we: got %b want 0", ifc.bus_we); end
    repeat (10) @(negedge clk);
    compared++; if (obs.size() !== 1) begin mismatched++;
      $display("FAIL flush_count: got %0d want 1", obs.size()); end
    compared++; if (obs[0] !== 8'ha0) begin mismatched++;
      $display("FAIL flush_byte: got %h want a0", obs[0]); end
    compared++; if (ifc.busy !== 1'b0) begin mismatched++;
      $display("FAIL flush_busy: got %b want 0", ifc.busy); end
  endtask

  task automatic test_reset_mid();
    int w;
    obs.delete();
    force_busy = 1'b1;
    tx_len = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data = 8'(8'hc0 + i);
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    force_busy = 1'b0;
    w = 0;
    @(negedge clk);
    while (!(ifc.bus_we && ifc.bus_addr == 32'hffff0024) && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #2;
    compared++; if (ifc.level !== 5'd3) begin mismatched++;
      $display("FAIL mid_level: got %0d want 3", ifc.level); end
    cfg_cnt = 0;
    rst = 1'b0;
    #1;
    compared++; if (ifc.level !== 5'd0) begin mismatched++;
      $display("FAIL mid_rst_lvl: got %0d want 0", ifc.level); end
    compared++; if (ifc.bus_we !== 1'b1) begin mismatched++;
      $display("FAIL mid_rst_we: got %b want 1", ifc.bus_we); end
    compared++; if (ifc.bus_addr !== 32'hffff0028) begin mismatched++;
      $display("FAIL mid_rst_addr: got %h want ffff0028", ifc.bus_addr); end
    compared++; if (ifc.in_ready !== 1'b1) begin mismatched++;
      $display("FAIL mid_rst_rdy: got %b want 1", ifc.in_ready); end
    compared++; if (ifc.busy !== 1'b1) begin mismatched++;
      $display("FAIL mid_rst_busy: got %b want 1", ifc.busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(negedge clk);
    compared++; if (cfg_cnt !== 1) begin mismatched++;
      $display("FAIL mid_cfg: got %0d want 1", cfg_cnt); end
    compared++; if (obs.size() !== 1) begin mismatched++;
      $display("FAIL mid_count: got %0d want 1", obs.size()); end
    compared++; if (ifc.level !== 5'd0) begin mismatched++;
      $display("FAIL mid_level0: got %0d want 0", ifc.level); end
    compared++; if (ifc.busy !== 1'b0) begin mismatched++;
      $display("FAIL mid_idle: got %b want 0", ifc.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
